// File: rtl/flex_stp_pkg.sv
// Shared definitions for the flex_stp_deser serial-to-parallel deserialiser:
// counter width helper, the all-ones fill used at reset/clear, and the
// shift-direction encoding.
package flex_stp_pkg;

  // Direction in which received bits travel through the shift register.
  typedef enum logic {
    SHIFT_TO_LSB = 1'b0,
    SHIFT_TO_MSB = 1'b1
  } shift_dir_e;

  // Fill value for every bit of the shift register and output buffer on
  // reset (and of the shift register on clear).
  localparam logic FILL_BIT = 1'b1;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 32'sd1);
  endfunction

endpackage

// File: rtl/flex_bit_counter.sv
// Bit counter for flex_stp_deser: counts enabled edges from 0 up to
// ROLLOVER_VAL and wraps to 0. rollover_flag is registered and is high
// while the count sits at ROLLOVER_VAL, i.e. the next enabled edge wraps.
// clear has priority over count_enable.
module flex_bit_counter #(
  parameter int               CNT_W        = 4,
  parameter logic [CNT_W-1:0] ROLLOVER_VAL = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  output logic [CNT_W-1:0] count,
  output logic             rollover_flag
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             at_roll_r;
  logic             at_roll_next_s;

  // Next count: clear, wrap at the rollover value, or increment.
  always_comb begin
    count_next_s = count_r;
    if (clear) begin
      count_next_s = {CNT_W{1'b0}};
    end else if (count_enable) begin
      if (count_r == ROLLOVER_VAL) begin
        count_next_s = {CNT_W{1'b0}};
      end else begin
        count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_next_s = count_r;
    end
    at_roll_next_s = (count_next_s == ROLLOVER_VAL);
  end

  // Count and rollover-pending registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r   <= {CNT_W{1'b0}};
      at_roll_r <= 1'b0;
    end else begin
      count_r   <= count_next_s;
      at_roll_r <= at_roll_next_s;
    end
  end

  assign count         = count_r;
  assign rollover_flag = at_roll_r;

endmodule

// File: rtl/flex_stp_deser.sv
// flex_stp_deser: framed serial-to-parallel deserialiser with a buffered
// output word, valid/ready handshake, sticky overrun flag and synchronous
// frame clear.
// Optional feature: define FLEX_STP_DESER_PARITY_EN to append one
// even-parity bit to every frame; parity_error then reports the check
// result alongside data_out. Without it parity_error is always 0.
module flex_stp_deser
  import flex_stp_pkg::*;
#(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 1
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              shift_enable,
  input  logic                              serial_in,
  input  logic                              clear,
  input  logic                              data_ready,
  output logic [NUM_BITS-1:0]               parallel_out,
  output logic [cnt_width(NUM_BITS)-1:0]    bit_count,
  output logic [NUM_BITS-1:0]               data_out,
  output logic                              data_valid,
  output logic                              overrun,
  output logic                              parity_error
);

  localparam int                  CNT_W      = cnt_width(NUM_BITS);
  localparam logic [NUM_BITS-1:0] RESET_WORD = {NUM_BITS{FILL_BIT}};
  localparam shift_dir_e          DIR        = (SHIFT_MSB != 0) ? SHIFT_TO_MSB : SHIFT_TO_LSB;

`ifdef FLEX_STP_DESER_PARITY_EN
  // Frame is NUM_BITS data bits followed by the parity bit.
  localparam logic [CNT_W-1:0] ROLL_VAL = CNT_W'(NUM_BITS);
`else
  localparam logic [CNT_W-1:0] ROLL_VAL = CNT_W'(NUM_BITS - 1);
`endif

  logic                shift_go_s;
  logic                shift_data_s;
  logic                last_s;
  logic                complete_s;
  logic                consume_s;
  logic                load_s;
  logic                drop_s;
  logic [NUM_BITS-1:0] shifted_s;
  logic [NUM_BITS-1:0] word_s;
  logic                word_perr_s;

  logic [NUM_BITS-1:0] parallel_r;
  logic [NUM_BITS-1:0] parallel_next_s;
  logic [NUM_BITS-1:0] data_out_r;
  logic [NUM_BITS-1:0] data_out_next_s;
  logic                data_valid_r;
  logic                data_valid_next_s;
  logic                overrun_r;
  logic                overrun_next_s;
  logic                parity_err_r;
  logic                parity_err_next_s;
  logic [CNT_W-1:0]    count_s;

  flex_bit_counter #(
    .CNT_W        (CNT_W),
    .ROLLOVER_VAL (ROLL_VAL)
  ) u_bit_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .count_enable  (shift_enable),
    .count         (count_s),
    .rollover_flag (last_s)
  );

  // Register contents after taking serial_in in the configured direction.
  generate
    if (DIR == SHIFT_TO_MSB) begin : g_to_msb
      assign shifted_s = {parallel_r[NUM_BITS-2:0], serial_in};
    end else begin : g_to_lsb
      assign shifted_s = {serial_in, parallel_r[NUM_BITS-1:1]};
    end
  endgenerate

  // clear discards the serial bit on its edge.
  assign shift_go_s = shift_enable & ~clear;
  assign complete_s = shift_go_s & last_s;

`ifdef FLEX_STP_DESER_PARITY_EN
  // Even parity: word plus parity bit must XOR to zero.
  function automatic logic parity_fail(input logic [NUM_BITS-1:0] word,
                                       input logic                pbit);
    return (^word) ^ pbit;
  endfunction

  // The parity edge does not shift; the word is already in the register
  // and the parity bit is consumed straight into the check.
  assign shift_data_s = shift_go_s & ~last_s;
  assign word_s       = parallel_r;
  assign word_perr_s  = parity_fail(parallel_r, serial_in);
`else
  // The last data edge completes the frame with the post-shift value.
  assign shift_data_s = shift_go_s;
  assign word_s       = shifted_s;
  assign word_perr_s  = 1'b0;
`endif

  // Handshake decode: a completed word loads if the buffer is free or is
  // being consumed on the same edge, otherwise it is dropped.
  assign consume_s = data_valid_r & data_ready;
  assign load_s    = complete_s & (~data_valid_r | data_ready);
  assign drop_s    = complete_s & data_valid_r & ~data_ready;

  // Next shift-register value.
  always_comb begin
    parallel_next_s = parallel_r;
    if (clear) begin
      parallel_next_s = RESET_WORD;
    end else if (shift_data_s) begin
      parallel_next_s = shifted_s;
    end else begin
      parallel_next_s = parallel_r;
    end
  end

  // Next output-buffer, valid and parity-result values.
  always_comb begin
    data_out_next_s   = data_out_r;
    parity_err_next_s = parity_err_r;
    data_valid_next_s = data_valid_r;
    if (load_s) begin
      data_out_next_s   = word_s;
      parity_err_next_s = word_perr_s;
      data_valid_next_s = 1'b1;
    end else if (consume_s) begin
      data_valid_next_s = 1'b0;
    end else begin
      data_valid_next_s = data_valid_r;
    end
  end

  // Next sticky overrun value; only clear (or reset) removes it.
  always_comb begin
    overrun_next_s = overrun_r;
    if (clear) begin
      overrun_next_s = 1'b0;
    end else if (drop_s) begin
      overrun_next_s = 1'b1;
    end else begin
      overrun_next_s = overrun_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parallel_r   <= RESET_WORD;
      data_out_r   <= RESET_WORD;
      data_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      parallel_r   <= parallel_next_s;
      data_out_r   <= data_out_next_s;
      data_valid_r <= data_valid_next_s;
      overrun_r    <= overrun_next_s;
      parity_err_r <= parity_err_next_s;
    end
  end

  assign parallel_out = parallel_r;
  assign bit_count    = count_s;
  assign data_out     = data_out_r;
  assign data_valid   = data_valid_r;
  assign overrun      = overrun_r;
  assign parity_error = parity_err_r;

endmodule

// File: tb/tb_flex_stp_deser.sv
// Self-checking bench for flex_stp_deser. Two instances (bits moving toward
// the MSB and toward the LSB) share one stimulus stream; a frame-level model
// predicts all outputs, checked every cycle, plus hand-computed literals.
`timescale 1ns/1ps
module tb_flex_stp_deser;

  localparam int NUM_BITS = 8;
  localparam int CNT_W    = 4;
`ifdef FLEX_STP_DESER_PARITY_EN
  localparam int FRAME  = NUM_BITS + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FRAME  = NUM_BITS;
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst, shift_enable, serial_in, clear, data_ready;
  logic [NUM_BITS-1:0] parallel_out_a, data_out_a, parallel_out_b, data_out_b;
  logic [CNT_W-1:0]    bit_count_a, bit_count_b;
  logic data_valid_a, overrun_a, parity_error_a;
  logic data_valid_b, overrun_b, parity_error_b;

  always #5 clk = ~clk;

  flex_stp_deser #(.NUM_BITS(NUM_BITS), .SHIFT_MSB(1)) dut_a (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .data_ready(data_ready), .parallel_out(parallel_out_a),
    .bit_count(bit_count_a), .data_out(data_out_a), .data_valid(data_valid_a),
    .overrun(overrun_a), .parity_error(parity_error_a));

  flex_stp_deser #(.NUM_BITS(NUM_BITS), .SHIFT_MSB(0)) dut_b (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .data_ready(data_ready), .parallel_out(parallel_out_b),
    .bit_count(bit_count_b), .data_out(data_out_b), .data_valid(data_valid_b),
    .overrun(overrun_b), .parity_error(parity_error_b));

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Model state: data bits since last reset/clear, bits of the open frame,
  // and the buffered word as seen by each instance.
  bit hist[$];
  bit frame_q[$];
  logic m_valid = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
  logic [NUM_BITS-1:0] m_out_a = '1, m_out_b = '1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift register = the most recent NUM_BITS data bits, ones where fewer.
  function automatic logic [NUM_BITS-1:0] exp_par(input bit to_msb);
    logic [NUM_BITS-1:0] v;
    int n;
    v = '1;
    n = hist.size();
    for (int i = 0; i < NUM_BITS && i < n; i++) begin
      if (to_msb) v[i] = hist[n-1-i];
      else        v[NUM_BITS-1-i] = hist[n-1-i];
    end
    return v;
  endfunction

  task automatic model_edge();
    bit completed, consume, px;
    logic [NUM_BITS-1:0] wa, wb;
    consume   = (m_valid === 1'b1) && (data_ready === 1'b1);
    completed = 1'b0;
    if (clear) begin
      hist.delete();
      frame_q.delete();
      m_ovr = 1'b0;
    end else if (shift_enable) begin
      frame_q.push_back(serial_in);
      if (frame_q.size() <= NUM_BITS) begin
        hist.push_back(serial_in);
        if (hist.size() > NUM_BITS) void'(hist.pop_front());
      end
      if (frame_q.size() == FRAME) completed = 1'b1;
    end
    if (completed) begin
      px = 1'b0;
      for (int i = 0; i < NUM_BITS; i++) begin
        wa[NUM_BITS-1-i] = frame_q[i];
        wb[i]            = frame_q[i];
      end
      for (int i = 0; i < FRAME; i++) px ^= frame_q[i];
      frame_q.delete();
      if (!m_valid || data_ready) begin
        m_out_a = wa;
        m_out_b = wb;
        m_perr  = PAR_EN ? px : 1'b0;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (consume) begin
      m_valid = 1'b0;
    end
  endtask

  // Model update on every clock edge and on asynchronous reset.
  initial forever begin
    @(posedge clk or negedge n_rst);
    if (!n_rst) begin
      hist.delete();
      frame_q.delete();
      m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      m_out_a = '1;   m_out_b = '1;
    end else begin
      model_edge();
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("par_a",   32'(parallel_out_a), 32'(exp_par(1'b1)));
      chk("par_b",   32'(parallel_out_b), 32'(exp_par(1'b0)));
      chk("cnt_a",   32'(bit_count_a),    32'(frame_q.size()));
      chk("cnt_b",   32'(bit_count_b),    32'(frame_q.size()));
      chk("dout_a",  32'(data_out_a),     32'(m_out_a));
      chk("dout_b",  32'(data_out_b),     32'(m_out_b));
      chk("valid_a", 32'(data_valid_a),   32'(m_valid));
      chk("valid_b", 32'(data_valid_b),   32'(m_valid));
      chk("ovr_a",   32'(overrun_a),      32'(m_ovr));
      chk("ovr_b",   32'(overrun_b),      32'(m_ovr));
      chk("perr_a",  32'(parity_error_a), 32'(m_perr));
      chk("perr_b",  32'(parity_error_b), 32'(m_perr));
    end
  end

  // Present inputs for exactly one rising edge, then return to idle.
  task automatic cyc(input logic se, input logic sin, input logic clr, input logic rdy);
    shift_enable = se; serial_in = sin; clear = clr; data_ready = rdy;
    @(posedge clk);
    #2;
    shift_enable = 1'b0; serial_in = 1'b0; clear = 1'b0; data_ready = 1'b0;
  endtask

  // Send one frame, MSB of w first; rdy_last asserts data_ready on the
  // completing edge only.
  task automatic send_word(input logic [NUM_BITS-1:0] w, input logic pbit, input logic rdy_last);
    for (int i = NUM_BITS-1; i >= 0; i--) begin
      cyc(1'b1, w[i], 1'b0, (FRAME == NUM_BITS && i == 0) ? rdy_last : 1'b0);
    end
    if (FRAME > NUM_BITS) cyc(1'b1, pbit, 1'b0, rdy_last);
  endtask

  initial begin
    logic [NUM_BITS-1:0] w;
    n_rst = 1'b0; shift_enable = 1'b0; serial_in = 1'b0; clear = 1'b0; data_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_par",   32'(parallel_out_a), 32'h0000_00FF);
    chk("rst_dout",  32'(data_out_a),     32'h0000_00FF);
    chk("rst_cnt",   32'(bit_count_a),    32'h0000_0000);
    chk("rst_valid", 32'(data_valid_a),   32'h0000_0000);
    chk("rst_ovr",   32'(overrun_a),      32'h0000_0000);
    chk("rst_perr",  32'(parity_error_a), 32'h0000_0000);
    cmp_en = 1'b1;
    n_rst  = 1'b1;

    // First frame 1,1,0,0,0,0,0,0 with bit_count walk and valid timing.
    w = 8'hC0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b1, (i < NUM_BITS) ? w[NUM_BITS-1-i] : 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("walk_cnt",   32'(bit_count_b),  32'((i + 1) % FRAME));
      chk("walk_valid", 32'(data_valid_a), (i == FRAME-1) ? 32'd1 : 32'd0);
    end
    chk("f1_dout_a", 32'(data_out_a),     32'h0000_00C0);
    chk("f1_dout_b", 32'(data_out_b),     32'h0000_0003);
    chk("f1_perr",   32'(parity_error_a), 32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("consume_valid", 32'(data_valid_a), 32'h0000_0000);

    // Overrun: second word dropped while first is still unread.
    send_word(8'hC0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr_dout", 32'(data_out_a), 32'h0000_00C0);
    chk("ovr_set",  32'(overrun_a),  32'h0000_0001);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("clr_ovr",   32'(overrun_a),    32'h0000_0000);
    chk("clr_valid", 32'(data_valid_a), 32'h0000_0001);

    // Back-to-back: consume on the completing edge of the next word.
    send_word(8'h5A, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_dout",  32'(data_out_a),   32'h0000_005A);
    chk("b2b_valid", 32'(data_valid_a), 32'h0000_0001);
    chk("b2b_ovr",   32'(overrun_a),    32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Clear after 3 bits; clear wins over a simultaneous shift.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mclr_cnt", 32'(bit_count_a),    32'h0000_0000);
    chk("mclr_par", 32'(parallel_out_b), 32'h0000_00FF);
    send_word(8'h96, 1'b0, 1'b0);
    @(negedge clk);
    chk("mclr_dout_a", 32'(data_out_a), 32'h0000_0096);
    chk("mclr_dout_b", 32'(data_out_b), 32'h0000_0069);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset after 5 bits.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    #1 n_rst = 1'b0;
    #1;
    chk("mrst_cnt", 32'(bit_count_a),    32'h0000_0000);
    chk("mrst_par", 32'(parallel_out_a), 32'h0000_00FF);
    @(negedge clk);
    n_rst = 1'b1;
    send_word(8'h3A, 1'b0, 1'b0);
    @(negedge clk);
    chk("mrst_dout_a", 32'(data_out_a), 32'h0000_003A);
    chk("mrst_dout_b", 32'(data_out_b), 32'h0000_005C);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef FLEX_STP_DESER_PARITY_EN
    // Parity: good frame, then a frame whose parity bit is wrong.
    send_word(8'hC0, 1'b0, 1'b0);
    @(negedge clk);
    chk("par_ok", 32'(parity_error_a), 32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = NUM_BITS-1; i >= 0; i--) begin
      w = 8'hC1;
      cyc(1'b1, w[i], 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("par_8th_valid", 32'(data_valid_a), 32'h0000_0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("par_9th_valid", 32'(data_valid_a),   32'h0000_0001);
    chk("par_bad",       32'(parity_error_a), 32'h0000_0001);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
